// File: rtl/dac_jesd204_channel_datagen_pkg.sv
// Shared definitions for the JESD204 DAC channel data generator and the ADC PN monitor:
// source-select encodings, PN polynomial taps and generator seeds.
package dac_jesd204_channel_datagen_pkg;

  typedef enum logic [3:0] {
    DATA_SEL_DMA  = 4'd0,
    DATA_SEL_PAT  = 4'd1,
    DATA_SEL_ZERO = 4'd2,
    DATA_SEL_PN7  = 4'd3,
    DATA_SEL_PN15 = 4'd4,
    DATA_SEL_RAMP = 4'd5
  } data_sel_e;

  // x^7 + x^6 + 1
  localparam int unsigned PN7_WIDTH = 7;
  localparam int unsigned PN7_TAP_A = 6;
  localparam int unsigned PN7_TAP_B = 5;
  localparam logic [6:0]  PN7_SEED  = 7'h7F;

  // x^15 + x^14 + 1
  localparam int unsigned PN15_WIDTH = 15;
  localparam int unsigned PN15_TAP_A = 14;
  localparam int unsigned PN15_TAP_B = 13;
  localparam logic [14:0] PN15_SEED  = 15'h7FFF;

  localparam int unsigned SRC_WIDTH = 16;

endpackage

// File: rtl/dac_jesd204_pngen.sv
// Fibonacci LFSR word generator: emits BITS new bits per cycle, first bit at data_o MSB.
// seed_i restarts from SEED in the same cycle, so the word it produces is the first word.
module dac_jesd204_pngen #(
  parameter int unsigned       WIDTH = 7,
  parameter int unsigned       TAP_A = 6,
  parameter int unsigned       TAP_B = 5,
  parameter logic [WIDTH-1:0]  SEED  = '1,
  parameter int unsigned       BITS  = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            seed_i,
  input  logic            advance_i,
  output logic [BITS-1:0] data_o
);

  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] state_d;
  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] s;
  logic             b;

  always_comb begin
    cur    = seed_i ? SEED : state_q;
    s      = cur;
    b      = 1'b0;
    data_o = '0;
    for (int unsigned k = 0; k < BITS; k++) begin
      b                 = s[TAP_A] ^ s[TAP_B];
      s                 = {s[WIDTH-2:0], b};
      data_o[BITS-1-k]  = b;
    end
    state_d = advance_i ? s : cur;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: rtl/dac_jesd204_channel_datagen.sv
// Per-channel DAC transmit data source: DMA, pattern, zero, PN7, PN15 or ramp,
// with optional offset-binary formatting and one output register stage.
module dac_jesd204_channel_datagen
  import dac_jesd204_channel_datagen_pkg::*;
#(
  parameter int unsigned CHANNEL_WIDTH   = 16,
  parameter int unsigned DATA_PATH_WIDTH = 2
) (
  input  logic                                     dac_clk,
  input  logic                                     dac_rstn,
  input  logic                                     dac_enable,
  input  logic [3:0]                               dac_data_sel,
  input  logic                                     dac_dfmt_type,
  input  logic [15:0]                              dac_pat_data_1,
  input  logic [15:0]                              dac_pat_data_2,
  input  logic                                     dac_sync,
  input  logic [16*DATA_PATH_WIDTH-1:0]            dac_dma_data,
  input  logic                                     dac_dma_valid,
  output logic                                     dac_dma_ready,
  output logic                                     dac_dma_underflow,
  output logic [CHANNEL_WIDTH*DATA_PATH_WIDTH-1:0] dac_data
);

  localparam int unsigned CW = CHANNEL_WIDTH;
  localparam int unsigned DW = CHANNEL_WIDTH * DATA_PATH_WIDTH;

  data_sel_e sel;
  logic      gen_seed;
  logic      pn7_adv;
  logic      pn15_adv;
  logic [DW-1:0] pn7_word;
  logic [DW-1:0] pn15_word;

  logic [CW-1:0] ramp_q;
  logic [CW-1:0] ramp_d;
  logic [CW-1:0] ramp_base;
  logic [CW-1:0] lane;
  logic [DW-1:0] data_q;
  logic [DW-1:0] data_d;
  logic          underflow_q;
  logic          underflow_d;
  logic          unused_src_lsbs;

  assign sel      = data_sel_e'(dac_data_sel);
  // Disabled channels are held at seed, so re-enabling restarts every sequence.
  assign gen_seed = dac_sync | ~dac_enable;
  assign pn7_adv  = dac_enable & (sel == DATA_SEL_PN7);
  assign pn15_adv = dac_enable & (sel == DATA_SEL_PN15);

  assign dac_dma_ready = dac_enable & (sel == DATA_SEL_DMA);

  assign unused_src_lsbs = ^{dac_pat_data_1, dac_pat_data_2, dac_dma_data};

  dac_jesd204_pngen #(
    .WIDTH (PN7_WIDTH),
    .TAP_A (PN7_TAP_A),
    .TAP_B (PN7_TAP_B),
    .SEED  (PN7_SEED),
    .BITS  (DW)
  ) u_pn7 (
    .clk_i     (dac_clk),
    .rst_ni    (dac_rstn),
    .seed_i    (gen_seed),
    .advance_i (pn7_adv),
    .data_o    (pn7_word)
  );

  dac_jesd204_pngen #(
    .WIDTH (PN15_WIDTH),
    .TAP_A (PN15_TAP_A),
    .TAP_B (PN15_TAP_B),
    .SEED  (PN15_SEED),
    .BITS  (DW)
  ) u_pn15 (
    .clk_i     (dac_clk),
    .rst_ni    (dac_rstn),
    .seed_i    (gen_seed),
    .advance_i (pn15_adv),
    .data_o    (pn15_word)
  );

  always_comb begin
    ramp_base = gen_seed ? '0 : ramp_q;
    ramp_d    = ramp_base;
    if (dac_enable && (sel == DATA_SEL_RAMP)) begin
      ramp_d = ramp_base + CW'(DATA_PATH_WIDTH);
    end
  end

  always_comb begin
    data_d      = '0;
    lane        = '0;
    underflow_d = dac_dma_ready & ~dac_dma_valid;
    for (int unsigned n = 0; n < DATA_PATH_WIDTH; n++) begin
      lane = '0;
      case (sel)
        DATA_SEL_DMA:  lane = dac_dma_valid ? dac_dma_data[SRC_WIDTH*n+SRC_WIDTH-1 -: CW] : '0;
        DATA_SEL_PAT:  lane = (n % 2 == 0) ? dac_pat_data_1[SRC_WIDTH-1 -: CW]
                                           : dac_pat_data_2[SRC_WIDTH-1 -: CW];
        DATA_SEL_PN7:  lane = pn7_word[DW-1-n*CW -: CW];
        DATA_SEL_PN15: lane = pn15_word[DW-1-n*CW -: CW];
        DATA_SEL_RAMP: lane = ramp_base + CW'(n);
        default:       lane = '0;
      endcase
      if (dac_dfmt_type) begin
        lane[CW-1] = ~lane[CW-1];
      end
      if (!dac_enable) begin
        lane = '0;
      end
      data_d[n*CW +: CW] = lane;
    end
  end

  always_ff @(posedge dac_clk or negedge dac_rstn) begin
    if (!dac_rstn) begin
      data_q      <= '0;
      underflow_q <= 1'b0;
      ramp_q      <= '0;
    end else begin
      data_q      <= data_d;
      underflow_q <= underflow_d;
      ramp_q      <= ramp_d;
    end
  end

  assign dac_data          = data_q;
  assign dac_dma_underflow = underflow_q;

endmodule

// File: tb/tb_dac_jesd204_channel_datagen.sv
// Directed bench for dac_jesd204_channel_datagen with a reference model feeding a scoreboard queue.
module tb_dac_jesd204_channel_datagen;

  logic        clk = 1'b0;
  logic        rstn;
  logic        en;
  logic [3:0]  sel;
  logic        dfmt;
  logic [15:0] pat1;
  logic [15:0] pat2;
  logic        sync;
  logic [31:0] dma;
  logic        valid;
  logic        ready;
  logic        uf;
  logic [31:0] data;
  logic        ready12;
  logic        uf12;
  logic [23:0] data12;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] data;
    logic        uf;
    logic [23:0] d12;
    bit          chk12;
  } exp_t;

  exp_t sb[$];

  logic [6:0]  m_pn7;
  logic [14:0] m_pn15;
  logic [15:0] m_ramp;

  always #5 clk = ~clk;

  dac_jesd204_channel_datagen #(.CHANNEL_WIDTH(16), .DATA_PATH_WIDTH(2)) dut (
    .dac_clk(clk), .dac_rstn(rstn), .dac_enable(en), .dac_data_sel(sel),
    .dac_dfmt_type(dfmt), .dac_pat_data_1(pat1), .dac_pat_data_2(pat2),
    .dac_sync(sync), .dac_dma_data(dma), .dac_dma_valid(valid),
    .dac_dma_ready(ready), .dac_dma_underflow(uf), .dac_data(data)
  );

  dac_jesd204_channel_datagen #(.CHANNEL_WIDTH(12), .DATA_PATH_WIDTH(2)) dut12 (
    .dac_clk(clk), .dac_rstn(rstn), .dac_enable(en), .dac_data_sel(sel),
    .dac_dfmt_type(dfmt), .dac_pat_data_1(pat1), .dac_pat_data_2(pat2),
    .dac_sync(sync), .dac_dma_data(dma), .dac_dma_valid(valid),
    .dac_dma_ready(ready12), .dac_dma_underflow(uf12), .dac_data(data12)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Bit-serial LFSR reference: bit k goes to lane k/16, MSB first.
  function automatic logic [31:0] pn_word(input int unsigned n, input logic [14:0] st_in,
                                          output logic [14:0] st_out);
    logic [14:0] st;
    logic [31:0] w;
    logic        b;
    st = st_in;
    w  = '0;
    for (int k = 0; k < 32; k++) begin
      b = st[n-1] ^ st[n-2];
      st = ((st << 1) | 15'(b)) & 15'((1 << n) - 1);
      w[(k / 16) * 16 + 15 - (k % 16)] = b;
    end
    st_out = st;
    return w;
  endfunction

  task automatic model_reset();
    m_pn7  = 7'h7F;
    m_pn15 = 15'h7FFF;
    m_ramp = 16'h0000;
  endtask

  task automatic model_expect(output exp_t e);
    logic [15:0] l0, l1;
    logic [14:0] ns;
    logic [31:0] w;
    if (sync || !en) model_reset();
    l0 = '0; l1 = '0; e.uf = 1'b0;
    if (en) begin
      case (sel)
        4'd0: if (valid) begin l0 = dma[15:0]; l1 = dma[31:16]; end else e.uf = 1'b1;
        4'd1: begin l0 = pat1; l1 = pat2; end
        4'd3: begin w = pn_word(7, {8'h00, m_pn7}, ns); m_pn7 = ns[6:0]; l0 = w[15:0]; l1 = w[31:16]; end
        4'd4: begin w = pn_word(15, m_pn15, ns); m_pn15 = ns; l0 = w[15:0]; l1 = w[31:16]; end
        4'd5: begin l0 = m_ramp; l1 = m_ramp + 16'd1; m_ramp = m_ramp + 16'd2; end
        default: ;
      endcase
      if (dfmt) begin l0[15] = ~l0[15]; l1[15] = ~l1[15]; end
    end
    e.data  = {l1, l0};
    e.d12   = {l1[15:4], l0[15:4]};
    e.chk12 = en && (sel == 4'd1);
  endtask

  task automatic cycle(input string tag);
    exp_t e;
    exp_t got;
    #1;
    check({tag, ".ready"}, 32'(ready), 32'(en && (sel == 4'd0)));
    model_expect(e);
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    check({tag, ".data"}, data, got.data);
    check({tag, ".underflow"}, 32'(uf), 32'(got.uf));
    if (got.chk12) check({tag, ".data12"}, 32'(data12), 32'(got.d12));
  endtask

  initial begin
    rstn = 1'b1; en = 1'b0; sel = 4'd0; dfmt = 1'b0; pat1 = '0; pat2 = '0;
    sync = 1'b0; dma = '0; valid = 1'b0;
    model_reset();

    #2 rstn = 1'b0;
    #1;
    check("reset.data", data, 32'h0);
    check("reset.underflow", 32'(uf), 32'h0);
    check("reset.data12", 32'(data12), 32'h0);
    @(negedge clk) rstn = 1'b1;
    cycle("idle");

    en = 1'b1; sel = 4'd5;
    cycle("ramp"); check("ramp.w0", data, 32'h0001_0000);
    cycle("ramp"); check("ramp.w1", data, 32'h0003_0002);
    cycle("ramp"); check("ramp.w2", data, 32'h0005_0004);
    for (int i = 0; i < 32764; i++) cycle("ramp");
    cycle("ramp_top");  check("ramp.top", data, 32'hFFFF_FFFE);
    cycle("ramp_wrap"); check("ramp.wrap", data, 32'h0001_0000);
    cycle("ramp");

    en = 1'b0;
    cycle("disable"); check("disable.zero", data, 32'h0);
    en = 1'b1;
    cycle("reenable"); check("reenable.ramp", data, 32'h0001_0000);
    cycle("ramp");

    sel = 4'd1; pat1 = 16'h1234; pat2 = 16'hABCD;
    cycle("pat");
    check("pat.cw16", data, 32'hABCD_1234);
    check("pat.cw12", 32'(data12), 32'h00AB_C123);
    dfmt = 1'b1;
    cycle("pat_ob");
    check("pat_ob.cw16", data, 32'h2BCD_9234);
    check("pat_ob.cw12", 32'(data12), 32'h002B_C923);
    sel = 4'd2; cycle("zero_ob");
    dfmt = 1'b0;
    cycle("zero");
    sel = 4'd7; cycle("sel7");

    sel = 4'd0; valid = 1'b1;
    dma = 32'h0002_0001; cycle("dma0"); check("dma0.w", data, 32'h0002_0001);
    dma = 32'h0004_0003; cycle("dma1");
    dma = 32'h0006_0005; cycle("dma2");
    valid = 1'b0; dma = 32'hDEAD_BEEF;
    cycle("dma_uf");
    check("dma_uf.zero", data, 32'h0);
    check("dma_uf.flag", 32'(uf), 32'h1);
    valid = 1'b1; dma = 32'h0008_0007;
    cycle("dma3"); check("dma3.noflag", 32'(uf), 32'h0);
    en = 1'b0; cycle("dma_dis_valid");
    valid = 1'b0; cycle("dma_dis_novalid");
    en = 1'b1;

    sel = 4'd3; sync = 1'b1;
    cycle("pn7_sync");
    sync = 1'b0;
    for (int i = 0; i < 5000; i++) cycle("pn7");

    sel = 4'd4; sync = 1'b1;
    cycle("pn15_sync");
    sync = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      if (i == 2500) sync = 1'b1;
      cycle("pn15");
      sync = 1'b0;
    end

    sel = 4'd3; cycle("pn7_keep"); cycle("pn7_keep");
    sel = 4'd5; cycle("ramp_keep");
    sel = 4'd3; cycle("pn7_keep"); cycle("pn7_keep");

    #2 rstn = 1'b0;
    #1;
    check("midreset.data", data, 32'h0);
    check("midreset.underflow", 32'(uf), 32'h0);
    model_reset();
    @(negedge clk) rstn = 1'b1;
    for (int i = 0; i < 40; i++) cycle("pn7_after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
